// File: rtl/io_bus_if.sv
// Command/response and IO-bus signal bundle between the host decoder, the bus
// master and the subsystems.
interface io_bus_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] rsp_status;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] bus_reg_address;
  logic              bus_RW;
  logic [DATA_W-1:0] bus_data_out;
  logic [DATA_W-1:0] bus_data_in;
  logic              bus_handshake_1;
  logic              bus_handshake_2;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
           bus_data_in, bus_handshake_2,
    output cmd_ready, rsp_valid, rsp_data, rsp_status, rsp_timeout,
           bus_reg_address, bus_RW, bus_data_out, bus_handshake_1
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
           bus_data_in, bus_handshake_2,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status, rsp_timeout,
           bus_reg_address, bus_RW, bus_data_out, bus_handshake_1
  );
endinterface

// File: rtl/io_bus_master.sv
// IO bus master: one register command at a time through the two-phase
// handshake_1/handshake_2 sequence (data word, then status word), with timeout.
module io_bus_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic       clk,
  input logic       reset,
  io_bus_if.master  bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, D_REQ, D_REL, S_REQ, S_REL, RESP} state_t;

  typedef struct packed {
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] rsp_status;
    logic              rsp_timeout;
    logic              h1;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } regs_t;

  localparam regs_t RST = '{state: IDLE, cnt: '0, cmd_ready: 1'b1, rsp_valid: 1'b0,
                            rsp_data: '0, rsp_status: '0, rsp_timeout: 1'b0,
                            h1: 1'b0, rw: 1'b1, addr: '0, wdata: '0};

  regs_t r, n;
  logic  wait_st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r <= RST;
    else        r <= n;
  end

  always_comb begin
    n       = r;
    wait_st = r.state inside {D_REQ, D_REL, S_REQ, S_REL};
    case (r.state)
      IDLE: begin
        // cmd_ready low in IDLE only after an abort: wait for the subsystem to let go
        if (!r.cmd_ready) begin
          if (!bus.bus_handshake_2) n.cmd_ready = 1'b1;
        end else if (bus.cmd_valid) begin
          n.rw          = bus.cmd_rw;
          n.addr        = bus.cmd_addr;
          n.wdata       = bus.cmd_wdata;
          n.cmd_ready   = 1'b0;
          n.h1          = 1'b1;
          n.rsp_data    = '0;
          n.rsp_status  = '0;
          n.rsp_timeout = 1'b0;
          n.state       = D_REQ;
        end
      end
      D_REQ: if (bus.bus_handshake_2) begin
        if (r.rw) n.rsp_data = bus.bus_data_in;
        n.h1    = 1'b0;
        n.state = D_REL;
      end
      D_REL: if (!bus.bus_handshake_2) begin
        n.h1    = 1'b1;
        n.state = S_REQ;
      end
      S_REQ: if (bus.bus_handshake_2) begin
        n.rsp_status = bus.bus_data_in;
        n.h1         = 1'b0;
        n.state      = S_REL;
      end
      S_REL: if (!bus.bus_handshake_2) begin
        n.rsp_valid = 1'b1;
        n.state     = RESP;
      end
      RESP: if (bus.rsp_ready) begin
        n.rsp_valid = 1'b0;
        n.cmd_ready = !r.rsp_timeout;
        n.state     = IDLE;
      end
      default: n.state = IDLE;
    endcase

    // a handshake edge arriving on the last allowed cycle still wins over the abort
    if (wait_st && n.state == r.state && r.cnt == CNT_MAX) begin
      n.h1          = 1'b0;
      n.rsp_timeout = 1'b1;
      n.rsp_status  = '1;
      n.rsp_valid   = 1'b1;
      n.state       = RESP;
    end
    n.cnt = (wait_st && n.state == r.state) ? r.cnt + 1'b1 : '0;
  end

  assign bus.cmd_ready       = r.cmd_ready;
  assign bus.rsp_valid       = r.rsp_valid;
  assign bus.rsp_data        = r.rsp_data;
  assign bus.rsp_status      = r.rsp_status;
  assign bus.rsp_timeout     = r.rsp_timeout;
  assign bus.bus_reg_address = r.addr;
  assign bus.bus_RW          = r.rw;
  assign bus.bus_data_out    = r.wdata;
  assign bus.bus_handshake_1 = r.h1;
endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master with a small subsystem model on the handshake
// pair: normal read/write, timeout, back-pressure, mid-transaction reset, stuck ack.
module tb_io_bus_master;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TO     = 1023;

  logic clk = 1'b0;
  logic reset = 1'b0;

  io_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif();

  io_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // subsystem model knobs
  int          ack_dly = 1;
  bit          mute = 0, stuck = 0, mdl_clr = 0;
  logic [31:0] data_val = '0, status_val = '0;
  int          dcnt;
  logic        phase;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bif.bus_handshake_2 <= 1'b0;
      dcnt  <= 0;
      phase <= 1'b0;
    end else begin
      if (stuck) bif.bus_handshake_2 <= 1'b1;
      else if (mute) bif.bus_handshake_2 <= 1'b0;
      else if (bif.bus_handshake_1 != bif.bus_handshake_2) begin
        if (dcnt >= ack_dly - 1) begin
          bif.bus_handshake_2 <= bif.bus_handshake_1;
          dcnt <= 0;
          if (bif.bus_handshake_2) phase <= !phase;
        end else dcnt <= dcnt + 1;
      end else dcnt <= 0;
      if (mdl_clr) phase <= 1'b0;
    end
  end

  assign bif.bus_data_in = bif.bus_handshake_2 ? (phase ? status_val : data_val) : 'z;

  int   rv_rises = 0;
  logic rv_q = 1'b0;
  always @(negedge clk) begin
    rv_q <= bif.rsp_valid;
    if (bif.rsp_valid && !rv_q) rv_rises <= rv_rises + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drives a command at a negedge; drv = cycle count when cmd_valid went high
  task automatic do_cmd(input logic rw, input logic [7:0] addr, input logic [31:0] wd,
                        output int drv);
    for (int i = 0; i < 20 && !bif.cmd_ready; i++) @(negedge clk);
    if (!bif.cmd_ready) check("cmd_ready_wait", 0, 1);
    bif.cmd_rw    = rw;
    bif.cmd_addr  = addr;
    bif.cmd_wdata = wd;
    bif.cmd_valid = 1'b1;
    drv = cyc;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int at);
    for (int i = 0; i < budget && !bif.rsp_valid; i++) @(negedge clk);
    if (!bif.rsp_valid) check("rsp_wait_expired", 0, 1);
    at = cyc;
  endtask

  task automatic consume();
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    bif.rsp_ready = 1'b0;
  endtask

  task automatic plain_read(input string tag, input logic [7:0] addr,
                            input logic [31:0] dv, input logic [31:0] sv);
    int drv, t;
    data_val = dv; status_val = sv; ack_dly = 1;
    do_cmd(1'b1, addr, '0, drv);
    wait_rsp(60, t);
    check({tag, "_data"}, bif.rsp_data, dv);
    check({tag, "_status"}, bif.rsp_status, sv);
    check({tag, "_timeout"}, bif.rsp_timeout, 0);
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drv, t, bad, r0, rise, fall;
    bit seen_fall;
    bif.cmd_valid = 0; bif.cmd_rw = 1; bif.cmd_addr = '0; bif.cmd_wdata = '0;
    bif.rsp_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bif.cmd_ready, 1);
    check("rst_rsp_valid", bif.rsp_valid, 0);
    check("rst_rsp_data", bif.rsp_data, 0);
    check("rst_rsp_status", bif.rsp_status, 0);
    check("rst_rsp_timeout", bif.rsp_timeout, 0);
    check("rst_h1", bif.bus_handshake_1, 0);
    check("rst_rw", bif.bus_RW, 1);
    check("rst_addr", bif.bus_reg_address, 0);
    check("rst_dout", bif.bus_data_out, 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: read SYS_INFO_0 from a zero-wait subsystem
    data_val = 32'h5159_0001; status_val = 32'h0; ack_dly = 1;
    do_cmd(1'b1, 8'h00, '0, drv);
    check("t1_h1_rise", bif.bus_handshake_1, 1);
    check("t1_h1_rise_cyc", cyc - drv, 1);
    wait_rsp(50, t);
    check("t1_latency", t - drv, 9);
    check("t1_data", bif.rsp_data, 32'h5159_0001);
    check("t1_status", bif.rsp_status, 0);
    check("t1_timeout", bif.rsp_timeout, 0);
    consume();
    check("t1_valid_clr", bif.rsp_valid, 0);
    check("t1_ready_back", bif.cmd_ready, 1);

    // 2: write with a 3-cycle subsystem
    data_val = 32'h7777_0000; status_val = 32'hA5; ack_dly = 3;
    r0 = rv_rises;
    do_cmd(1'b0, 8'h10, 32'hDEAD_BEEF, drv);
    bad = 0;
    for (int i = 0; i < 200 && !bif.rsp_valid; i++) begin
      if (bif.bus_data_out !== 32'hDEAD_BEEF || bif.bus_RW !== 1'b0 ||
          bif.bus_reg_address !== 8'h10) bad++;
      @(negedge clk);
    end
    check("t2_rsp_valid", bif.rsp_valid, 1);
    check("t2_bus_stable", bad, 0);
    check("t2_data_zero", bif.rsp_data, 0);
    check("t2_status", bif.rsp_status, 32'hA5);
    consume();
    repeat (3) @(negedge clk);
    check("t2_one_pulse", rv_rises - r0, 1);

    // 3: handshake_2 never rises -> timeout
    mute = 1;
    do_cmd(1'b1, 8'hEE, '0, drv);
    rise = cyc;
    for (int i = 0; i < TO + 50 && bif.bus_handshake_1; i++) @(negedge clk);
    fall = cyc;
    check("t3_h1_width", fall - rise, TO);
    check("t3_rsp_valid", bif.rsp_valid, 1);
    check("t3_timeout", bif.rsp_timeout, 1);
    check("t3_status", bif.rsp_status, 32'hFFFF_FFFF);
    check("t3_data", bif.rsp_data, 0);
    consume();
    mute = 0;
    for (int i = 0; i < 5 && !bif.cmd_ready; i++) @(negedge clk);
    check("t3_ready_back", bif.cmd_ready, 1);

    // 4: response back-pressure with the next command waiting
    data_val = 32'h0BAD_F00D; status_val = 32'h11; ack_dly = 1;
    do_cmd(1'b1, 8'h05, '0, drv);
    wait_rsp(50, t);
    bif.cmd_valid = 1; bif.cmd_rw = 0; bif.cmd_addr = 8'h22; bif.cmd_wdata = 32'h1234_5678;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bif.rsp_data !== 32'h0BAD_F00D || bif.rsp_status !== 32'h11 || !bif.rsp_valid ||
          bif.rsp_timeout || bif.cmd_ready || bif.bus_handshake_1) bad++;
    end
    check("t4_hold", bad, 0);
    bif.rsp_ready = 1;
    @(negedge clk);
    bif.rsp_ready = 0;
    check("t4_retired", bif.rsp_valid, 0);
    check("t4_ready", bif.cmd_ready, 1);
    check("t4_h1_idle", bif.bus_handshake_1, 0);
    @(negedge clk);
    bif.cmd_valid = 0;
    check("t4_second_start", bif.bus_handshake_1, 1);
    check("t4_second_busy", bif.cmd_ready, 0);
    check("t4_second_addr", bif.bus_reg_address, 8'h22);
    check("t4_second_rw", bif.bus_RW, 0);
    wait_rsp(50, t);
    check("t4_second_data", bif.rsp_data, 0);
    consume();

    // 5: reset while in S_REQ
    data_val = 32'h2222_0002; status_val = 32'h33; ack_dly = 3;
    do_cmd(1'b1, 8'h01, '0, drv);
    seen_fall = 0;
    for (int i = 0; i < 100; i++) begin
      if (!seen_fall && !bif.bus_handshake_1) seen_fall = 1;
      else if (seen_fall && bif.bus_handshake_1) break;
      @(negedge clk);
    end
    check("t5_in_sreq", bif.bus_handshake_1, 1);
    reset = 1'b0;
    #1;
    check("t5_h1_async", bif.bus_handshake_1, 0);
    check("t5_rsp_valid", bif.rsp_valid, 0);
    check("t5_cmd_ready", bif.cmd_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    plain_read("t5_after", 8'h03, 32'h4444_0004, 32'h55);

    // 6: handshake_2 stuck high -> abort in D_REL, then wait for release
    data_val = 32'h6666_0006; status_val = 32'h77; ack_dly = 1;
    stuck = 1;
    do_cmd(1'b1, 8'h02, '0, drv);
    wait_rsp(TO + 50, t);
    check("t6_timeout", bif.rsp_timeout, 1);
    check("t6_status", bif.rsp_status, 32'hFFFF_FFFF);
    check("t6_data_kept", bif.rsp_data, 32'h6666_0006);
    consume();
    bif.cmd_valid = 1; bif.cmd_rw = 1; bif.cmd_addr = 8'h03;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bif.cmd_ready || bif.bus_handshake_1) bad++;
    end
    check("t6_blocked", bad, 0);
    bif.cmd_valid = 0;
    stuck = 0; mdl_clr = 1;
    @(negedge clk);
    mdl_clr = 0;
    for (int i = 0; i < 5 && !bif.cmd_ready; i++) @(negedge clk);
    check("t6_ready_after_release", bif.cmd_ready, 1);
    plain_read("t6_after", 8'h04, 32'h8888_0008, 32'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
